// File: rtl/ss_scan_driver.sv
// Four-digit multiplexed seven-segment driver. Patterns shift in from the right,
// digits are scanned with a programmable dwell, and the display can optionally blink.
module ss_scan_driver #(
    parameter int          REFRESH_DIV = 100000,
    parameter int          BLINK_HALF  = 25000000,
    parameter logic [7:0]  BLANK       = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pat_in,
    input  logic       pat_valid,
    input  logic       clear,
    input  logic       blink_en,
    output logic [7:0] ssd_seg,
    output logic [3:0] ssd_an,
    output logic [2:0] count
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_HALF);

    typedef enum logic {ST_ON, ST_OFF} blink_state_t;

    logic [3:0][7:0] disp_buf_q, disp_buf_d;
    logic [2:0]      count_q, count_d;
    logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [BW-1:0]   blk_cnt_q, blk_cnt_d;
    blink_state_t    state_q, state_d;
    logic [7:0]      ssd_seg_q, ssd_seg_d;
    logic [3:0]      ssd_an_q, ssd_an_d;

    always_comb begin
        disp_buf_d = disp_buf_q;
        count_d    = count_q;
        ref_cnt_d  = ref_cnt_q;
        idx_d      = idx_q;
        blk_cnt_d  = blk_cnt_q;
        state_d    = state_q;
        ssd_seg_d  = ssd_seg_q;
        ssd_an_d   = ssd_an_q;

        // Clear wins over a same-cycle load; the presented pattern is dropped.
        if (clear) begin
            disp_buf_d = {4{BLANK}};
            count_d    = 3'd0;
        end else if (pat_valid) begin
            disp_buf_d = {disp_buf_q[2], disp_buf_q[1], disp_buf_q[0], pat_in};
            count_d    = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
        end

        if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
        end else begin
            ref_cnt_d = ref_cnt_q + RW'(1);
        end

        if (!blink_en) begin
            state_d   = ST_ON;
            blk_cnt_d = '0;
        end else if (blk_cnt_q == BW'(BLINK_HALF - 1)) begin
            blk_cnt_d = '0;
            state_d   = (state_q == ST_ON) ? ST_OFF : ST_ON;
        end else begin
            blk_cnt_d = blk_cnt_q + BW'(1);
        end

        // Gate on the effective blink state so dropping blink_en relights at once.
        if (state_d == ST_ON) begin
            ssd_an_d  = ~(4'b0001 << idx_q);
            ssd_seg_d = disp_buf_q[idx_q];
        end else begin
            ssd_an_d  = 4'b1111;
            ssd_seg_d = BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_buf_q <= {4{BLANK}};
            count_q    <= 3'd0;
            ref_cnt_q  <= '0;
            idx_q      <= 2'd0;
            blk_cnt_q  <= '0;
            state_q    <= ST_ON;
            ssd_seg_q  <= BLANK;
            ssd_an_q   <= 4'b1111;
        end else begin
            disp_buf_q <= disp_buf_d;
            count_q    <= count_d;
            ref_cnt_q  <= ref_cnt_d;
            idx_q      <= idx_d;
            blk_cnt_q  <= blk_cnt_d;
            state_q    <= state_d;
            ssd_seg_q  <= ssd_seg_d;
            ssd_an_q   <= ssd_an_d;
        end
    end

    assign ssd_seg = ssd_seg_q;
    assign ssd_an  = ssd_an_q;
    assign count   = count_q;

endmodule

// File: tb/tb_ss_scan_driver.sv
// Bench for ss_scan_driver: scan timing, shift-in, clear priority, load latency,
// blink phases and asynchronous reset, against a small reference model.
module tb_ss_scan_driver;

    localparam int RD = 4;
    localparam int BH = 16;
    localparam int W  = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pat_in = 8'h00;
    logic       pat_valid = 1'b0;
    logic       clear = 1'b0;
    logic       blink_en = 1'b0;
    logic [7:0] ssd_seg;
    logic [3:0] ssd_an;
    logic [2:0] count;

    ss_scan_driver #(.REFRESH_DIV(RD), .BLINK_HALF(BH), .BLANK(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .pat_in(pat_in), .pat_valid(pat_valid),
        .clear(clear), .blink_en(blink_en), .ssd_seg(ssd_seg), .ssd_an(ssd_an),
        .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    // reference model: buffer, count, and edges elapsed since reset release
    logic [7:0] m_buf[4];
    int m_count;
    int m_n;

    typedef struct {
        logic       pv;
        logic       clr;
        logic [7:0] pat;
        logic [2:0] exp_count;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_buf[i] = 8'hFF;
        m_count = 0;
        m_n = 0;
    endtask

    // one clock edge; expected outputs are pushed before the edge and popped after it
    task automatic tick(input logic pv, input logic clr, input logic [7:0] pat, input bit chk_disp);
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic [W-1:0] rec;
        int idx;
        pat_valid = pv;
        clear = clr;
        pat_in = pat;
        idx = (m_n / RD) % 4;
        e_an = ~(4'b0001 << idx);
        e_seg = m_buf[idx];
        if (clr) begin
            for (int i = 0; i < 4; i++) m_buf[i] = 8'hFF;
            m_count = 0;
        end else if (pv) begin
            m_buf[3] = m_buf[2];
            m_buf[2] = m_buf[1];
            m_buf[1] = m_buf[0];
            m_buf[0] = pat;
            m_count = (m_count < 4) ? m_count + 1 : 4;
        end
        exp_q.push_back({e_an, e_seg, 3'(m_count)});
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
        clear = 1'b0;
        m_n++;
        rec = exp_q.pop_front();
        if (chk_disp) begin
            check("an", {12'h0, ssd_an}, {12'h0, rec[14:11]});
            check("seg", {8'h0, ssd_seg}, {8'h0, rec[10:3]});
        end
        check("count", {13'h0, count}, {13'h0, rec[2:0]});
    endtask

    initial begin
        logic [7:0] dig[4];
        int hits;
        int f;
        int run;
        bit lit[80];

        vecs[0] = '{1'b1, 1'b0, 8'hA1, 3'd1};
        vecs[1] = '{1'b1, 1'b0, 8'hA2, 3'd2};
        vecs[2] = '{1'b1, 1'b0, 8'hA3, 3'd3};
        vecs[3] = '{1'b1, 1'b0, 8'hA4, 3'd4};
        vecs[4] = '{1'b1, 1'b0, 8'hA5, 3'd4};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 3'd4};

        // reset and idle scan
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", {12'h0, ssd_an}, 16'h000F);
        check("rst_seg", {8'h0, ssd_seg}, 16'h00FF);
        check("rst_count", {13'h0, count}, 16'h0000);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("first_an", {12'h0, ssd_an}, 16'h000E);
        for (int i = 0; i < 19; i++) tick(1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b1);

        // shift-in table, back-to-back loads
        for (int i = 0; i < 6; i++) begin
            tick(vecs[i].pv, vecs[i].clr, vecs[i].pat, 1'b1);
            check("tbl_count", {13'h0, count}, {13'h0, vecs[i].exp_count});
        end
        for (int i = 0; i < 4; i++) dig[i] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1);
            case (ssd_an)
                4'b1110: dig[0] = ssd_seg;
                4'b1101: dig[1] = ssd_seg;
                4'b1011: dig[2] = ssd_seg;
                4'b0111: dig[3] = ssd_seg;
                default: ;
            endcase
        end
        check("digit0", {8'h0, dig[0]}, 16'h00A5);
        check("digit1", {8'h0, dig[1]}, 16'h00A4);
        check("digit2", {8'h0, dig[2]}, 16'h00A3);
        check("digit3", {8'h0, dig[3]}, 16'h00A2);

        // clear beats a same-cycle load
        tick(1'b1, 1'b1, 8'h55, 1'b1);
        check("clr_count", {13'h0, count}, 16'h0000);
        hits = 0;
        for (int i = 0; i < 17; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1);
            if (ssd_seg == 8'h55) hits++;
        end
        check("clr_no55", 16'(hits), 16'h0000);

        // load latency while digit 0 is scanned
        while ((m_n % 16) != 0) tick(1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b1, 1'b0, 8'h3C, 1'b1);
        check("lat_pre", {8'h0, ssd_seg}, 16'h00FF);
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("lat_seg", {8'h0, ssd_seg}, 16'h003C);
        check("lat_an", {12'h0, ssd_an}, 16'h000E);

        // blink: measure OFF and following ON run lengths
        blink_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0);
            lit[i] = (ssd_an != 4'b1111);
            if (!lit[i]) check("blink_off_seg", {8'h0, ssd_seg}, 16'h00FF);
        end
        f = 0;
        while (f < 80 && lit[f]) f++;
        check("blink_first_off", 16'(f <= BH), 16'h0001);
        run = 0;
        while (f < 80 && !lit[f]) begin run++; f++; end
        check("blink_off_len", 16'(run), 16'(BH));
        run = 0;
        while (f < 80 && lit[f]) begin run++; f++; end
        check("blink_on_len", 16'(run), 16'(BH));
        run = 0;
        while (ssd_an != 4'b1111 && run < 40) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0);
            run++;
        end
        check("blink_reach_off", {12'h0, ssd_an}, 16'h000F);
        blink_en = 1'b0;
        tick(1'b0, 1'b0, 8'h00, 1'b1);

        // async reset with idx=2 and count=3
        tick(1'b0, 1'b1, 8'h00, 1'b1);
        tick(1'b1, 1'b0, 8'h11, 1'b1);
        tick(1'b1, 1'b0, 8'h22, 1'b1);
        tick(1'b1, 1'b0, 8'h33, 1'b1);
        while ((m_n % 16) != 9) tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("pre_rst_count", {13'h0, count}, 16'h0003);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_an", {12'h0, ssd_an}, 16'h000F);
        check("async_count", {13'h0, count}, 16'h0000);
        check("async_seg", {8'h0, ssd_seg}, 16'h00FF);
        #2;
        rst_n = 1'b1;
        model_reset();
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("post_rst_an", {12'h0, ssd_an}, 16'h000E);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
